// File: rtl/wptr_full_if.sv
// Write-side FIFO pointer bundle: producer request, synchronised read pointer,
// and the pointer/flag outputs of wptr_full.
interface wptr_full_if #(
  parameter int ADDR_SIZE = 3
);
  logic                 winc;
  logic                 wovf_clr;
  logic [ADDR_SIZE:0]   wq2_rptr;
  logic [ADDR_SIZE:0]   wptr;
  logic [ADDR_SIZE-1:0] waddr;
  logic                 wr_en;
  logic                 wfull;
  logic                 walmost_full;
  logic [ADDR_SIZE:0]   wlevel;
  logic                 woverflow;

  modport master (
    output winc, wovf_clr, wq2_rptr,
    input  wptr, waddr, wr_en, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wovf_clr, wq2_rptr,
    output wptr, waddr, wr_en, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full.sv
// Async FIFO write-domain pointer: binary/Gray write pointer, full and
// almost-full flags, conservative fill level and sticky overflow.
module wptr_full #(
  parameter int ADDR_SIZE = 3,
  parameter int AF_LEVEL  = 6
) (
  input logic       wclk,
  input logic       wrst,
  wptr_full_if.slave bus
);
  localparam logic [ADDR_SIZE:0] AF_THRESH = AF_LEVEL[ADDR_SIZE:0];

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wgray;
  logic [ADDR_SIZE:0] level;
  logic               full;
  logic               almost_full;
  logic               overflow;

  logic               wr_en;
  logic [ADDR_SIZE:0] wbin_next;
  logic [ADDR_SIZE:0] wgray_next;
  logic [ADDR_SIZE:0] rbin_s;
  logic [ADDR_SIZE:0] full_mask;
  logic [ADDR_SIZE:0] level_next;

  // Reset must also block the write strobe, since fifo_mem is not reset.
  assign wr_en      = bus.winc & ~full & ~wrst;
  assign wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, wr_en};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign level_next = wbin_next - rbin_s;

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      rbin_s[i] = ^(bus.wq2_rptr >> i);
    end
  end

  // Full in Gray space: top two bits inverted, the rest identical.
  always_comb begin
    full_mask                = '0;
    full_mask[ADDR_SIZE]     = 1'b1;
    full_mask[ADDR_SIZE-1]   = 1'b1;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin        <= '0;
      wgray       <= '0;
      level       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      level       <= level_next;
      full        <= (wgray_next == (bus.wq2_rptr ^ full_mask));
      almost_full <= (level_next >= AF_THRESH);
      if (bus.winc && full) begin
        overflow <= 1'b1;
      end else if (bus.wovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.wptr         = wgray;
  assign bus.waddr        = wbin[ADDR_SIZE-1:0];
  assign bus.wr_en        = wr_en;
  assign bus.wfull        = full;
  assign bus.walmost_full = almost_full;
  assign bus.wlevel       = level;
  assign bus.woverflow    = overflow;
endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full (ADDR_SIZE=3, AF_LEVEL=6) with hand-computed expectations.
module tb_wptr_full;
  logic wclk = 1'b0;
  logic wrst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wptr_full_if #(.ADDR_SIZE(3)) bus ();

  wptr_full #(.ADDR_SIZE(3), .AF_LEVEL(6)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return (v >> 1) ^ v;
  endfunction

  task automatic edge_sample();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wptr"},  bus.wptr, 0);
    chk({tag, "_waddr"}, bus.waddr, 0);
    chk({tag, "_wren"},  bus.wr_en, 0);
    chk({tag, "_full"},  bus.wfull, 0);
    chk({tag, "_afull"}, bus.walmost_full, 0);
    chk({tag, "_level"}, bus.wlevel, 0);
    chk({tag, "_ovf"},   bus.woverflow, 0);
  endtask

  initial begin
    bus.winc     = 1'b1;
    bus.wovf_clr = 1'b0;
    bus.wq2_rptr = 4'b0000;
    #2;
    chk_all_zero("reset");
    bus.winc = 1'b0;
    @(negedge wclk);
    wrst = 1'b0;
    edge_sample();
    chk_all_zero("idle");

    // Fill all 8 entries with the read side parked at 0.
    for (int i = 0; i < 8; i++) begin
      bus.winc = 1'b1;
      #1;
      chk("fill_waddr", bus.waddr, i);
      chk("fill_wren", bus.wr_en, 1);
      edge_sample();
      chk("fill_level", bus.wlevel, i + 1);
      chk("fill_afull", bus.walmost_full, (i + 1 >= 6) ? 1 : 0);
      chk("fill_full", bus.wfull, (i == 7) ? 1 : 0);
    end
    chk("full_wptr", bus.wptr, 4'b1100);

    // Writes while full are dropped and latch overflow.
    for (int i = 0; i < 2; i++) begin
      bus.winc = 1'b1;
      #1;
      chk("ovf_wren", bus.wr_en, 0);
      chk("ovf_waddr", bus.waddr, 0);
      edge_sample();
      chk("ovf_flag", bus.woverflow, 1);
      chk("ovf_wptr", bus.wptr, 4'b1100);
      chk("ovf_level", bus.wlevel, 8);
    end
    bus.winc = 1'b0;
    edge_sample();
    chk("ovf_hold", bus.woverflow, 1);
    bus.wovf_clr = 1'b1;
    edge_sample();
    chk("ovf_clr", bus.woverflow, 0);
    bus.wovf_clr = 1'b0;

    // Read side frees one slot.
    bus.wq2_rptr = 4'b0001;
    edge_sample();
    chk("rec_full", bus.wfull, 0);
    chk("rec_level", bus.wlevel, 7);
    chk("rec_afull", bus.walmost_full, 1);
    bus.winc = 1'b1;
    #1;
    chk("rec_waddr", bus.waddr, 0);
    chk("rec_wren", bus.wr_en, 1);
    edge_sample();
    chk("refull_full", bus.wfull, 1);
    chk("refull_wptr", bus.wptr, 4'b1101);
    chk("refull_level", bus.wlevel, 8);

    // Set beats a simultaneous clear.
    bus.wovf_clr = 1'b1;
    edge_sample();
    chk("setwins_ovf", bus.woverflow, 1);
    bus.wovf_clr = 1'b0;

    // Async reset mid-burst, checked before any clock edge.
    #1;
    wrst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    edge_sample();
    chk_all_zero("rst_held");
    bus.wq2_rptr = 4'b0000;
    @(negedge wclk);
    wrst = 1'b0;

    // 40 writes with the read pointer trailing two behind.
    for (int n = 0; n < 40; n++) begin
      bus.winc = 1'b1;
      bus.wq2_rptr = (n == 0) ? 4'b0000 : to_gray(n - 1);
      #1;
      chk("trail_waddr", bus.waddr, n % 8);
      chk("trail_wren", bus.wr_en, 1);
      edge_sample();
      chk("trail_wptr", bus.wptr, to_gray(n + 1));
      chk("trail_level", bus.wlevel, (n == 0) ? 1 : 2);
      chk("trail_full", bus.wfull, 0);
      chk("trail_afull", bus.walmost_full, 0);
    end
    bus.winc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-side pointer and full-flag generator for the asynchronous FIFO, in the write-clock domain, directly upstream of fifo_mem.
- Accepts write requests, drives the memory's write address and write enable, and exports a Gray-coded write pointer for synchronisation into the read domain.
- Consumes the read pointer after it has been synchronised into wclk, and derives full, almost-full, fill level and a sticky overflow flag from it.

Parameters:
- ADDR_SIZE, 3, memory address width; DEPTH = 2^ADDR_SIZE; legal range ≥1.
- AF_LEVEL, 6, fill level at or above which walmost_full asserts; legal range 1..DEPTH.

Ports:
- wclk  input  1  write clock; all state updates on the rising edge.
- wrst  input  1  asynchronous active-high reset.
- winc  input  1  write request from the producer for this cycle.
- wovf_clr  input  1  synchronous clear of woverflow.
- wq2_rptr  input  ADDR_SIZE+1  read pointer in Gray code, already two-flop synchronised into wclk.
- wptr  output  ADDR_SIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
- waddr  output  ADDR_SIZE  memory write address; connects to fifo_mem waddr.
- wr_en  output  1  memory write enable; connects to fifo_mem wr_en.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered almost-full flag.
- wlevel  output  ADDR_SIZE+1  registered conservative fill level, 0..DEPTH.
- woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- State: wbin (ADDR_SIZE+1 bits, binary) and wptr (Gray), both registered.
- waddr = wbin[ADDR_SIZE-1:0], combinational from the register.
- wr_en = winc & ~wfull, combinational. fifo_mem captures wdata on the same wclk edge that advances wbin.
- Next-state computation:
  - wbin_next = wbin + wr_en, modulo 2^(ADDR_SIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - On each edge: wbin <= wbin_next; wptr <= wgray_next.
- Full detection:
  - wfull <= 1 when wgray_next equals wq2_rptr with its two MSBs inverted and all remaining bits equal; otherwise 0.
  - wfull therefore asserts in the cycle immediately after the DEPTH-th unread write.
- Fill level:
  - rbin_s = Gray-to-binary of wq2_rptr (bit i = XOR of wq2_rptr[ADDR_SIZE:i]).
  - wlevel <= (wbin_next - rbin_s) modulo 2^(ADDR_SIZE+1).
  - The level is pessimistic (over-reports) because the synchronised read pointer lags; it never under-reports.
- walmost_full <= (wbin_next - rbin_s) >= AF_LEVEL, unsigned compare.
- Invariant: wfull == (wlevel == DEPTH) on every cycle after the first post-reset edge.
- Full recovery: wfull deasserts on the first edge after wq2_rptr advances. There is no extra latency beyond the synchroniser.
- Overflow:
  - woverflow <= 1 when winc & wfull.
  - Otherwise woverflow <= 0 when wovf_clr.
  - Otherwise it holds.
  - Set has priority over a simultaneous clear.
  - A write attempted while full is dropped: wr_en stays 0 and wbin does not change.
- Wrap-around: wbin wraps from 2^(ADDR_SIZE+1)-1 to 0. The extra MSB disambiguates full from empty; no special casing beyond modulo arithmetic.
- Reset (async assert, any time, including mid-burst):
  - wbin, wptr, wlevel = 0; wfull, walmost_full, woverflow = 0.
  - wr_en = 0 while wrst is high, regardless of winc.
  - Memory contents are not touched.
  - Deassertion is synchronised externally.
- Behaviour is undefined for wq2_rptr values that move by more than one Gray step per cycle, or that run ahead of wptr. The verification bench must not drive them.

Test Plan:
- Reset then idle, wq2_rptr=0 → wptr=0000, waddr=0, wlevel=0, wfull=0, walmost_full=0, woverflow=0, wr_en=0.
- 8 consecutive winc=1, wq2_rptr=0 (DEPTH=8):
  - waddr steps 0..7, wr_en=1 each cycle.
  - walmost_full=1 after the 6th edge.
  - After the 8th edge: wfull=1, wlevel=8, wptr=1100.
- From full, winc=1 for 2 cycles → wr_en=0, wbin unchanged, waddr=0, woverflow=1 and held; then wovf_clr=1 with winc=0 → woverflow=0 next edge.
- From full, wq2_rptr changes 0000→0001 → next edge: wfull=0, wlevel=7; next winc writes waddr=0; then wfull=1 again with wptr=1101.
- 40 writes with wq2_rptr tracking two writes behind (valid Gray steps):
  - wptr sequence follows Gray code through the 4-bit wrap.
  - wlevel stays 2, wfull never set.
  - waddr wraps 7→0 cleanly.
- Assert wrst mid-burst with wfull=1 and woverflow=1, winc=1 → all outputs 0 immediately without a clock; winc=1 with wovf_clr=1 on the same edge while full → woverflow=1 (set wins).
